h264_pixel_packer: RTL



---
 rtl/h264_pixel_packer.sv | 96 +++++++++
 1 files changed

// File: rtl/h264_pixel_packer.sv
// h264_pixel_packer
// Packs an 8-bit pixel byte stream into 64-bit little-endian words for the
// encoder pixel FIFO. It enforces frame framing, pads the last word of a
// frame and throttles the source from the FIFO write-side fill level.
module h264_pixel_packer #(
    parameter logic [7:0] PAD_BYTE     = 8'h00,
    parameter logic [7:0] AFULL_THRESH = 8'd56
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_sof,
    input  logic        s_eof,
    output logic        s_ready,
    output logic [63:0] fifo_data,
    output logic        fifo_wrreq,
    input  logic [7:0]  fifo_wrusedw,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [63:0] PAD_WORD = {8{PAD_BYTE}};

    logic [0:0]  state;
    logic [2:0]  idx;
    logic [63:0] word_reg;

    logic        accept;
    logic        restart;
    logic [2:0]  lane;
    logic [63:0] merged;

    assign accept  = s_valid && s_ready;
    assign restart = s_sof;
    assign busy    = (state == ST_ACTIVE);

    // Work out where the incoming byte lands and the word it produces; a
    // start-of-frame byte always begins a fresh all-pad word at lane 0.
    always_comb begin
        lane   = restart ? 3'd0 : idx;
        merged = restart ? PAD_WORD : word_reg;
        merged[{lane, 3'b000} +: 8] = s_data;
    end

    // Framing state machine, word assembly, FIFO write strobe and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= 3'd0;
            word_reg   <= PAD_WORD;
            fifo_data  <= 64'h0;
            fifo_wrreq <= 1'b0;
            frame_cnt  <= 16'd0;
            err_cnt    <= 8'd0;
            s_ready    <= 1'b0;
        end else begin
            s_ready    <= (fifo_wrusedw < AFULL_THRESH);
            fifo_wrreq <= 1'b0;
            if (accept) begin
                if ((state == ST_IDLE) && !s_sof) begin
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end else begin
                    if ((state == ST_ACTIVE) && s_sof && (err_cnt != 8'hFF)) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                    if (s_eof) begin
                        fifo_data  <= merged;
                        fifo_wrreq <= 1'b1;
                        word_reg   <= PAD_WORD;
                        idx        <= 3'd0;
                        frame_cnt  <= frame_cnt + 16'd1;
                        state      <= ST_IDLE;
                    end else if (lane == 3'd7) begin
                        fifo_data  <= merged;
                        fifo_wrreq <= 1'b1;
                        word_reg   <= PAD_WORD;
                        idx        <= 3'd0;
                        state      <= ST_ACTIVE;
                    end else begin
                        word_reg   <= merged;
                        idx        <= lane + 3'd1;
                        state      <= ST_ACTIVE;
                    end
                end
            end
        end
    end

endmodule
